// File: rtl/mdu_pkg.sv
// Shared encodings and default sizing for the iterative multiply/divide unit.
// Both mdu_seq and its users import this package.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    typedef enum logic {
        OP_MULTU = 1'b0,
        OP_DIVU  = 1'b1
    } mdu_op_e;

endpackage

// File: rtl/cla_adder.sv
// Carry-lookahead adder: full lookahead inside each 4-bit group, with the
// group carries rippled from one group to the next. Purely combinational.
module cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NGRP = WIDTH / 4;

    logic [NGRP:0] grp_c;

    assign grp_c[0] = cin;

    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
            logic [3:0] g;
            logic [3:0] p;
            logic [3:0] c;

            assign g = a[gi*4 +: 4] & b[gi*4 +: 4];
            assign p = a[gi*4 +: 4] ^ b[gi*4 +: 4];

            assign c[0] = grp_c[gi];
            assign c[1] = g[0] | (p[0] & c[0]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c[0]);

            // Group carry-out from group generate/propagate terms.
            assign grp_c[gi+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                               | (p[3] & p[2] & p[1] & g[0])
                               | (p[3] & p[2] & p[1] & p[0] & c[0]);

            assign sum[gi*4 +: 4] = p ^ c;
        end
    endgenerate

    assign cout = grp_c[NGRP];

endmodule

// File: rtl/mdu_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) sequencer.
// One shared carry-lookahead adder is used once per iteration for both ops.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mdu_state_e       state_q, state_d;
    mdu_op_e          op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout;
    logic [WIDTH-1:0] rem;
    logic             div_ok;
    logic             mul_c;
    logic [WIDTH-1:0] mul_s;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    // Divide works on {hi, lo msb}; the bit shifted out of hi lands in div_ok.
    assign rem = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

    always_comb begin
        if (op_q == OP_DIVU) begin
            add_a   = rem;
            add_b   = ~b_q;
            add_cin = 1'b1;
        end else begin
            add_a   = hi_q;
            add_b   = b_q;
            add_cin = 1'b0;
        end
    end

    cla_adder #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        mul_c   = 1'b0;
        mul_s   = hi_q;
        div_ok  = hi_q[WIDTH-1] | add_cout;
        iter_hi = hi_q;
        iter_lo = lo_q;
        if (op_q == OP_DIVU) begin
            iter_hi = div_ok ? add_sum : rem;
            iter_lo = {lo_q[WIDTH-2:0], div_ok};
        end else begin
            if (lo_q[0]) begin
                mul_c = add_cout;
                mul_s = add_sum;
            end
            iter_hi = {mul_c, mul_s[WIDTH-1:1]};
            iter_lo = {mul_s[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        dz_d    = dz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d    = mdu_op_e'(op);
                    b_d     = src_b;
                    hi_d    = '0;
                    lo_d    = src_a;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    hi_d  = iter_hi;
                    lo_d  = iter_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        dz_d    = (op_q == OP_DIVU) && (b_q == '0);
                    end else begin
                        busy_d = 1'b1;
                    end
                end
            end
            DONE: begin
                // Result already committed; a flush here cannot retract it.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_MULTU;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: expected HI/LO/dz come from a behavioural
// model, are queued at start and compared when done pulses.
module tb_mdu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         flush = 1'b0;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    mdu_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        if (o == 1'b0) begin
            p    = {32'd0, a} * {32'd0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
        end else if (b == '0) begin
            e.hi = a;
            e.lo = '1;
            e.dz = 1'b1;
        end else begin
            e.hi = a % b;
            e.lo = a / b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Start one op and follow it to done; extra_at>0 pulses start again mid-run.
    task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int extra_at);
        int   n;
        bit   got;
        bit   busy_ok;
        exp_t e;
        sb.push_back(model(o, a, b));
        op = o; src_a = a; src_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_accept"}, 64'(busy), 64'd1);
        n = 0; got = 0; busy_ok = 1;
        while (n < 100 && !got) begin
            tick();
            n++;
            start = 1'b0;
            if (done) begin
                got = 1;
            end else begin
                if (busy !== 1'b1) busy_ok = 0;
                if (n == extra_at) begin
                    start = 1'b1; op = ~o; src_a = ~a; src_b = a;
                end
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'd32);
        check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
        if (got) begin
            check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check({tag, "_hi"}, 64'(hi), 64'(e.hi));
                check({tag, "_lo"}, 64'(lo), 64'(e.lo));
                check({tag, "_dz"}, 64'(dz), 64'(e.dz));
            end
            tick();
            check({tag, "_done_pulse"}, 64'(done), 64'd0);
            check({tag, "_hold_lo"}, 64'(lo), 64'(e.lo));
        end
    endtask

    initial begin
        int  seen;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dz", 64'(dz), 64'd0);

        run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 0);
        run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7, 0);
        run_op("div_msb", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_by0", 1'b1, 32'd5, 32'd0, 0);

        // Flush after 10 iterations of a MULTU: no done, dz keeps its value.
        op = 1'b0; src_a = 32'h1234; src_b = 32'h55; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_dz", 64'(dz), 64'd1);
        tick();
        run_op("div_9_3_extra", 1'b1, 32'd9, 32'd3, 5);
        seen = 0;
        repeat (40) begin
            tick();
            if (done) seen++;
        end
        check("flush_no_stray_done", 64'(seen), 64'd0);

        run_op("mul_3x3", 1'b0, 32'd3, 32'd3, 0);

        // start and flush together in IDLE: not accepted.
        op = 1'b0; src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("start_flush_busy", 64'(busy), 64'd0);
        tick();
        check("start_flush_busy2", 64'(busy), 64'd0);

        run_op("div_8_0", 1'b1, 32'd8, 32'd0, 0);

        // Reset in the middle of a DIVU.
        op = 1'b1; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_dz", 64'(dz), 64'd0);
        run_op("mul_after_rst", 1'b0, 32'd12, 32'd12, 0);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'($urandom_range(1, 255)) : $urandom;
            run_op("rand", 1'(i % 2), ra, rb, 0);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer for the Self_CPU execute stage.
- Time-shares one WIDTH-bit carry-lookahead adder (cla_adder, built from 4-bit lookahead groups) across WIDTH iterations.
- Supports unsigned shift-add multiply (MULTU) and unsigned restoring divide (DIVU), with a start/busy/done handshake to the pipeline stall logic.
- Results go to the HI/LO registers.

Parameters:
- WIDTH, 32: operand width. Must be a multiple of 4 (lookahead group size).
- CNT_W, 6: iteration counter width. Must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  operation request. Sampled only in IDLE.
- op  in  1  0 = MULTU, 1 = DIVU. Sampled with start.
- src_a  in  WIDTH  multiplicand / dividend.
- src_b  in  WIDTH  multiplier / divisor.
- flush  in  1  pipeline exception kill. Aborts the operation in flight.
- busy  out  1  operation in progress (stall request).
- done  out  1  one-cycle result-valid pulse.
- hi  out  WIDTH  MULTU: product[2W-1:W]; DIVU: remainder.
- lo  out  WIDTH  MULTU: product[W-1:0]; DIVU: quotient.
- dz  out  1  divide-by-zero flag for the last completed DIVU.

Behaviour:
- Reset:
  - rst_n=0 at a rising edge sets the state to IDLE.
  - busy=0, done=0, hi=0, lo=0, dz=0, counter=0.
  - Reset has priority over every other input, including mid-operation; no done is produced for an operation killed by reset.
- States: IDLE, RUN, DONE. Encoding lives in mdu_pkg.
- IDLE:
  - When start=1 and flush=0 at edge k: latch op and src_b, load working registers, set counter=0, go to RUN.
  - MULTU load: hi=0, lo=src_a.
  - DIVU load: hi=0, lo=src_a (dividend).
- RUN:
  - One iteration per edge, at edges k+1 through k+WIDTH.
  - After iteration WIDTH (counter==WIDTH-1): go to DONE.
  - busy=1 in every cycle following edges k through k+WIDTH-1.
- MULTU iteration:
  - If lo[0]=1, {c,s} = hi + mcand via cla_adder with cin=0; otherwise {c,s} = {0,hi}.
  - Then {hi,lo} <= {c,s,lo[WIDTH-1:1]}.
- DIVU iteration:
  - Form {t,r} = {hi,lo[WIDTH-1]}, which is WIDTH+1 bits.
  - Trial difference: d = r + ~divisor with cin=1, carry-out co.
  - ok = t | co.
  - hi <= ok ? d : r; lo <= {lo[WIDTH-2:0], ok}.
- DONE:
  - done=1 and busy=0 for exactly one cycle, following edge k+WIDTH.
  - Next edge returns to IDLE.
  - hi/lo hold their values until the next accepted start.
  - dz is updated at DONE: 1 if DIVU and divisor==0, else 0.
- Total latency: done is asserted WIDTH cycles after the cycle in which start was accepted.
- Divide by zero:
  - No special path; the restoring algorithm yields lo=all-ones and hi=dividend.
  - dz=1 marks the result.
- start while busy or done=1: ignored; no queuing.
- start and flush in the same IDLE cycle: flush wins and the operation is not accepted.
- flush=1 in RUN: next edge goes to IDLE, busy=0, done never pulses, hi/lo undefined to consumers, dz unchanged.
- flush=1 in DONE: done still pulses that cycle (already committed).
- No arithmetic beyond the shared adder: one adder use per iteration, both ops.
- Adder carry-out width: WIDTH+1 total; no overflow flag required.

Decomposition:
- mdu_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - op encoding (OP_MULTU=1'b0, OP_DIVU=1'b1).
  - default WIDTH constant.
- Sub-module cla_adder:
  - Parameter WIDTH; ports a, b, cin, sum, cout.
  - Ripples group carries through 4-bit generate/propagate lookahead groups.
  - Instantiated exactly once inside mdu_seq.
  - Independently testable, purely combinational.
- mdu_seq holds the FSM, counter, hi/lo working registers and operand mux.

Test Plan:
- MULTU src_a=7, src_b=6: done exactly 32 cycles after start; hi=0, lo=42 (0x2A), dz=0.
- MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001; busy high for 32 cycles, done a single-cycle pulse.
- DIVU src_a=100, src_b=7: lo=14, hi=2, dz=0. Repeat with src_a=0x80000000, src_b=0xFFFFFFFF: lo=0, hi=0x80000000.
- DIVU src_a=5, src_b=0: lo=0xFFFFFFFF, hi=5, dz=1. A following MULTU 3*3 gives lo=9 and clears dz to 0.
- flush at iteration 10 of a MULTU: busy falls next cycle and no done is seen. A new start one cycle later for DIVU 9/3 completes with lo=3, hi=0. A start pulse during busy has no effect on the result or timing.
- rst_n=0 for one edge mid-DIVU: all outputs 0 next cycle, state IDLE, no done. A start immediately after reset release is accepted.
